// File: rtl/kolache_mux_pkg.sv
// Shared definitions for the 16:1 select mux and its 1:16 register demux.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package kolache_mux_pkg;

    localparam int MUX_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // The mux select bus is the bit-reversed index: sel[0] carries index bit 3.
    function automatic logic [3:0] mux_sel_to_idx(input logic [3:0] sel);
        return {sel[0], sel[1], sel[2], sel[3]};
    endfunction

    // Bit reversal is its own inverse, so the same mapping serves both ways.
    function automatic logic [3:0] idx_to_mux_sel(input logic [3:0] idx);
        return mux_sel_to_idx(idx);
    endfunction

endpackage

// File: rtl/dec4to16.sv
// 4-bit index to 16-bit one-hot write strobe, gated by an enable.
// Latency: combinational.
// Backpressure: none; en low forces an all-zero strobe.
//   idx    : bit index to select (plain binary, not mux encoding)
//   en     : strobe enable
//   onehot : single set bit at position idx when en is high
module dec4to16
    import kolache_mux_pkg::*;
(
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [MUX_N-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = en;
    end

endmodule

// File: rtl/demux16_sreg.sv
// Registered 1:16 demux: direct addressed write or 16-beat scan into held bits.
// Latency: y updates one edge after load / valid beat; done one edge after last beat or abort.
// Backpressure: din_valid low stalls the scan; load/scan_start are dropped outside IDLE.
//   clk, rst   : clock, synchronous active-high reset
//   din        : data bit to route
//   s          : direct-write address in mux encoding
//   load       : direct write (IDLE only)
//   scan_start : start a 16-beat scan (IDLE only, beats load)
//   din_valid  : qualifies din during a scan
//   scan_abort : end a scan early (beats a concurrent valid beat)
//   y          : held output bits, y[i] pairs with mux input a<i>
//   s_mux      : index the next scan beat writes, in mux encoding
//   busy       : scan in progress
//   done       : one-cycle pulse when a scan completes or aborts
module demux16_sreg
    import kolache_mux_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic [3:0]  s,
    input  logic        load,
    input  logic        scan_start,
    input  logic        din_valid,
    input  logic        scan_abort,
    output logic [15:0] y,
    output logic [3:0]  s_mux,
    output logic        busy,
    output logic        done
);

    state_t           state;
    logic [3:0]       cnt;
    logic [3:0]       wr_idx;
    logic             wr_en;
    logic [MUX_N-1:0] wr_strobe;

    // One decoder serves both write paths; the state picks the address source.
    always_comb begin
        wr_idx = mux_sel_to_idx(s);
        wr_en  = 1'b0;
        case (state)
            IDLE: wr_en = load & ~scan_start;
            SCAN: begin
                wr_idx = cnt;
                wr_en  = din_valid & ~scan_abort;
            end
            default: wr_en = 1'b0;
        endcase
    end

    dec4to16 u_dec (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (wr_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            y     <= RESET_VAL;
        end else begin
            y <= (y & ~wr_strobe) | (wr_strobe & {MUX_N{din}});
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        cnt   <= 4'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_abort) begin
                        // Clear cnt so s_mux reads 0 once the scan is over.
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else if (din_valid) begin
                        cnt <= cnt + 4'd1;  // wraps to 0 after beat 15
                        if (cnt == 4'd15) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign s_mux = idx_to_mux_sel(cnt);
    assign busy  = (state == SCAN);
    assign done  = (state == DONE);

endmodule
